// File: rtl/panda_pkg.sv
// Shared types for the panda execute-stage units.
package panda_pkg;

    typedef enum logic [1:0] {
        DIV  = 2'b00,
        DIVU = 2'b01,
        REM  = 2'b10,
        REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ITER  = 2'b01,
        FIXUP = 2'b10,
        DONE  = 2'b11
    } div_state_e;

endpackage

// File: rtl/panda_divider_if.sv
// Request/response handshake between the execute stage and the divider.
interface panda_divider_if
    import panda_pkg::*;
#(
    parameter int unsigned Width = 32
);
    logic             valid_i;
    logic             ready_o;
    div_op_e          op_i;
    logic [Width-1:0] operand_a_i;
    logic [Width-1:0] operand_b_i;
    logic             kill_i;
    logic             valid_o;
    logic             ready_i;
    logic [Width-1:0] result_o;

    modport master (
        output valid_i, op_i, operand_a_i, operand_b_i, kill_i, ready_i,
        input  ready_o, valid_o, result_o
    );

    modport slave (
        input  valid_i, op_i, operand_a_i, operand_b_i, kill_i, ready_i,
        output ready_o, valid_o, result_o
    );
endinterface

// File: rtl/panda_comparator_sub.sv
// Magnitude compare derived from a precomputed a-b difference, signed or unsigned.
module panda_comparator_sub #(
    parameter int unsigned Width = 33
) (
    input  logic             sign_i,
    input  logic [Width-1:0] operand_a_i,
    input  logic [Width-1:0] operand_b_i,
    input  logic [Width-1:0] sub_result_i,
    output logic             is_less_o
);
    logic unused_sub_low;

    // Matching MSBs keep the difference in range, so its MSB is the answer.
    always_comb begin
        if (operand_a_i[Width-1] == operand_b_i[Width-1]) begin
            is_less_o = sub_result_i[Width-1];
        end else if (sign_i) begin
            is_less_o = operand_a_i[Width-1];
        end else begin
            is_less_o = operand_b_i[Width-1];
        end
    end

    assign unused_sub_low = ^sub_result_i[Width-2:0];

endmodule

// File: rtl/panda_divider.sv
// Iterative restoring divider for RV32M DIV/DIVU/REM/REMU.
// One Width+1-bit compare/subtract step per cycle; special cases resolve at accept.
module panda_divider
    import panda_pkg::*;
#(
    parameter int unsigned Width = 32
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    panda_divider_if.slave div_if
);
    localparam int unsigned      CntW    = $clog2(Width);
    localparam logic [CntW-1:0]  CntInit = CntW'(Width - 1);
    localparam logic [Width-1:0] MinNeg  = {1'b1, {(Width-1){1'b0}}};
    localparam logic [Width-1:0] AllOnes = '1;

    div_state_e       state_q, state_d;
    div_op_e          op_q, op_d;
    logic             sign_a_q, sign_a_d;
    logic             sign_b_q, sign_b_d;
    logic [Width-1:0] rem_q, rem_d;
    logic [Width-1:0] quo_q, quo_d;
    logic [Width-1:0] abs_b_q, abs_b_d;
    logic [Width-1:0] result_q, result_d;
    logic [CntW-1:0]  cnt_q, cnt_d;

    logic             req_signed, req_rem, a_neg, b_neg;
    logic             div_zero, overflow;
    logic [Width-1:0] abs_a, abs_b;

    logic [Width:0]   trial, divisor_ext, diff;
    logic             is_less;

    function automatic logic [Width-1:0] negate(input logic [Width-1:0] v);
        return ~v + Width'(1);
    endfunction

    // Request decode, valid only while sampling an incoming request.
    always_comb begin
        req_signed = ~div_if.op_i[0];
        req_rem    = div_if.op_i[1];
        a_neg      = req_signed & div_if.operand_a_i[Width-1];
        b_neg      = req_signed & div_if.operand_b_i[Width-1];
        abs_a      = a_neg ? negate(div_if.operand_a_i) : div_if.operand_a_i;
        abs_b      = b_neg ? negate(div_if.operand_b_i) : div_if.operand_b_i;
        div_zero   = (div_if.operand_b_i == '0);
        overflow   = req_signed && (div_if.operand_a_i == MinNeg) &&
                     (div_if.operand_b_i == AllOnes);
    end

    assign trial       = {rem_q, quo_q[Width-1]};
    assign divisor_ext = {1'b0, abs_b_q};
    assign diff        = trial - divisor_ext;

    panda_comparator_sub #(
        .Width (Width + 1)
    ) u_cmp (
        .sign_i       (1'b0),
        .operand_a_i  (trial),
        .operand_b_i  (divisor_ext),
        .sub_result_i (diff),
        .is_less_o    (is_less)
    );

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        abs_b_d  = abs_b_q;
        result_d = result_q;
        cnt_d    = cnt_q;

        unique case (state_q)
            IDLE: begin
                if (div_if.valid_i && !div_if.kill_i) begin
                    op_d     = div_if.op_i;
                    sign_a_d = a_neg;
                    sign_b_d = b_neg;
                    abs_b_d  = abs_b;
                    rem_d    = '0;
                    quo_d    = abs_a;
                    cnt_d    = CntInit;
                    if (div_zero) begin
                        result_d = req_rem ? div_if.operand_a_i : AllOnes;
                        state_d  = DONE;
                    end else if (overflow) begin
                        result_d = req_rem ? '0 : div_if.operand_a_i;
                        state_d  = DONE;
                    end else begin
                        state_d = ITER;
                    end
                end
            end
            ITER: begin
                // Restore keeps the shifted partial remainder; otherwise take the difference.
                if (is_less) begin
                    rem_d = trial[Width-1:0];
                    quo_d = {quo_q[Width-2:0], 1'b0};
                end else begin
                    rem_d = diff[Width-1:0];
                    quo_d = {quo_q[Width-2:0], 1'b1};
                end
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q == '0) begin
                    state_d = FIXUP;
                end
            end
            FIXUP: begin
                case (op_q)
                    DIV:     result_d = (sign_a_q ^ sign_b_q) ? negate(quo_q) : quo_q;
                    REM:     result_d = sign_a_q ? negate(rem_q) : rem_q;
                    DIVU:    result_d = quo_q;
                    default: result_d = rem_q;
                endcase
                state_d = DONE;
            end
            DONE: begin
                if (div_if.ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (div_if.kill_i) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            op_q     <= DIV;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            rem_q    <= '0;
            quo_q    <= '0;
            abs_b_q  <= '0;
            result_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            abs_b_q  <= abs_b_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
        end
    end

    assign div_if.ready_o  = (state_q == IDLE) & ~div_if.kill_i;
    assign div_if.valid_o  = (state_q == DONE);
    assign div_if.result_o = result_q;

endmodule

// File: doc/panda_divider.md
# panda_divider

Iterative multi-cycle integer divider for the RV32M DIV/DIVU/REM/REMU instructions. It sits beside the ALU in the execute stage. It sequences one (Width+1)-bit subtract/compare datapath through Width restoring-division steps and applies RISC-V sign and special-case rules. The execute stage stalls on the request handshake and collects the result on the response handshake.

## Interface
- Width, 32, operand/result width in bits (≥ 2)
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  reset, asynchronous, active-low
- valid_i  in  1  request valid
- ready_o  out  1  divider can accept a request
- op_i  in  2  div_op_e: DIV=00, DIVU=01, REM=10, REMU=11 (funct3[1:0])
- operand_a_i  in  Width  dividend
- operand_b_i  in  Width  divisor
- kill_i  in  1  flush: abandon any in-flight operation
- valid_o  out  1  result valid
- ready_i  in  1  consumer accepts result
- result_o  out  Width  quotient or remainder

## Operation
- States: IDLE, ITER, FIXUP, DONE.
- ready_o = (state==IDLE) & ~kill_i.
- Accept on valid_i & ready_o. Latch op, operand_a_i and sign flags. Signed ops use |a| and |b|; unsigned ops use raw values.
- Special cases are decided at accept and go IDLE→DONE directly:
  - Divide by zero (b==0): DIV/DIVU → all ones; REM/REMU → a.
  - Signed overflow (DIV/REM, a==1<<(Width-1), b==all ones): DIV → a; REM → 0.
- Otherwise go IDLE→ITER with rem=0, quo=|a|, count=Width-1.
- Each ITER cycle:
  - trial = {rem, quo[Width-1]} (Width+1 bits).
  - If trial ≥ {0,|b|} (unsigned): rem = trial − |b|, and shift 1 into quo.
  - Else: rem = trial[Width-1:0], and shift 0 into quo.
  - count decrements. When count==0, go to FIXUP.
- FIXUP computes result_o and goes to DONE:
  - DIV: quo, negated if sign_a ^ sign_b.
  - REM: rem, negated if sign_a.
  - DIVU: quo. REMU: rem.
- DONE: valid_o=1, result_o held stable. On ready_i, go to IDLE.
- kill_i has priority in every state. Next state is IDLE, valid_o deasserts next cycle, the operation is discarded, and no request is accepted that cycle.
- All arithmetic is modulo 2^Width. Negation is two's complement; negating the most-negative value yields itself.

## Timing
- Reset: state=IDLE, valid_o=0, result_o=0, internal regs=0. ready_o=1 when kill_i=0.
- Normal latency: accept edge at cycle 0, ITER in cycles 1..Width, FIXUP in cycle Width+1, valid_o high from cycle Width+2. That is 34 cycles for Width=32.
- Special-case latency: valid_o high at cycle 1.
- Throughput: one operation in flight. The next accept is possible in the cycle after the valid_o & ready_i handshake.
- valid_o, once high, stays high with result_o unchanged until ready_i or kill_i.
- Reset asserted mid-operation clears state asynchronously, with no result emitted.

## Structure
- Shared package panda_pkg:
  - div_op_e enum, values 2'b00–2'b11.
  - div_state_e enum (IDLE, ITER, FIXUP, DONE).
- The trial compare uses the existing panda_comparator_sub with Width+1 and sign_i=0. Its is_less_o selects restore/no-restore.
  - operand_a_i = trial.
  - operand_b_i = {1'b0, |b|}.
  - sub_result_i = trial − {1'b0, |b|}.
- Counter width is $clog2(Width). The rest lives in a single module.

## Test plan
- DIV 7 / −2 (0x00000007, 0xFFFFFFFE) → 0xFFFFFFFD, valid_o at cycle 34; REM same operands → 0x00000001.
- REM −7 / 2 → 0xFFFFFFFF; DIVU 0xFFFFFFFF / 0x10 → 0x0FFFFFFF; REMU same operands → 0xF.
- Divide by zero at cycle 1:
  - DIV 5 / 0 → 0xFFFFFFFF.
  - REMU 5 / 0 → 5.
- Overflow at cycle 1:
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000.
  - REM same operands → 0.
  - DIVU same operands → 0x00000000 after 34 cycles.
- Back-pressure and back-to-back requests:
  - Hold ready_i low 5 cycles after valid_o → result_o stable and ready_o low throughout.
  - Second request accepted in the cycle after the handshake.
- Abort paths:
  - kill_i in ITER cycle 10 → valid_o never rises and ready_o is high next cycle.
  - kill_i with valid_i in IDLE → not accepted.
  - rst_ni low mid-ITER → outputs at reset values immediately.
